// File: rtl/mesh_term_inject_arb.sv
// Round-robin injection arbiter feeding one mesh terminal input port.
// Optional per-source grant counters: define MESH_TERM_ARB_STATS_EN.
module mesh_term_inject_arb #(
    parameter int N_REQ     = 4,
    parameter int PAKG_SIZE = 32,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           req_pndng,
    input  logic [N_REQ*PAKG_SIZE-1:0] req_data,
    output logic [N_REQ-1:0]           req_pop,
    output logic                       pndng_i_in,
    output logic [PAKG_SIZE-1:0]       data_out_i_in,
    input  logic                       popin,
    output logic [ID_W-1:0]            grant_id,
    output logic                       proto_err
`ifdef MESH_TERM_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]        grant_cnt
`endif
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     win;
    logic                found;
    logic                grant;
    logic [PAKG_SIZE-1:0] win_data;

    // First pending source after the last winner, wrapping mod N_REQ.
    always_comb begin
        int idx;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(rr_ptr) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && req_pndng[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_data = req_data[win*PAKG_SIZE +: PAKG_SIZE];

    always_comb begin
        grant     = 1'b0;
        state_nxt = state;
        req_pop   = '0;
        if (!reset && enable && found)
            grant = (state == IDLE) || popin;
        unique case (state)
            IDLE: if (grant) state_nxt = HOLD;
            HOLD: if (popin && !grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (grant)
            req_pop[win] = 1'b1;
    end

    assign pndng_i_in = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= ID_W'(N_REQ - 1);
            data_out_i_in <= '0;
            grant_id      <= '0;
            proto_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                data_out_i_in <= win_data;
                grant_id      <= win;
                rr_ptr        <= win;
            end
            if (popin && state == IDLE)
                proto_err <= 1'b1;
        end
    end

`ifdef MESH_TERM_ARB_STATS_EN
    logic [15:0] cnt [N_REQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++)
                cnt[i] <= '0;
        end else if (grant && cnt[win] != 16'hFFFF) begin
            cnt[win] <= cnt[win] + 16'd1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_mesh_term_inject_arb.sv
// Directed self-checking bench for mesh_term_inject_arb (N_REQ=4).
module tb_mesh_term_inject_arb;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int IW = 2;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [N-1:0]    req_pndng;
    logic [N*PW-1:0] req_data;
    logic [N-1:0]    req_pop;
    logic            pndng_i_in;
    logic [PW-1:0]   data_out_i_in;
    logic            popin;
    logic [IW-1:0]   grant_id;
    logic            proto_err;
`ifdef MESH_TERM_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    int passed;
    int total;

    mesh_term_inject_arb #(
        .N_REQ(N),
        .PAKG_SIZE(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .req_pndng(req_pndng),
        .req_data(req_data),
        .req_pop(req_pop),
        .pndng_i_in(pndng_i_in),
        .data_out_i_in(data_out_i_in),
        .popin(popin),
        .grant_id(grant_id),
        .proto_err(proto_err)
`ifdef MESH_TERM_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data_a0;
        for (int i = 0; i < N; i++)
            req_data[i*PW +: PW] = 32'hA0 + i;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        popin = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        enable    = 1'b1;
        popin     = 1'b0;
        req_pndng = 4'b1111;
        set_data_a0();
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (req_pop !== 4'b0 || pndng_i_in !== 1'b0 ||
                grant_id !== 2'd0 || proto_err !== 1'b0 ||
                data_out_i_in !== 32'h0)
                $display("FAIL reset_outs c=%0d pop=%b v=%b id=%0d err=%b d=%h",
                         c, req_pop, pndng_i_in, grant_id, proto_err,
                         data_out_i_in);
            else passed++;
        end
        reset = 1'b0;
        #1;
        total++;
        if (req_pop !== 4'b0001)
            $display("FAIL reset_first_pop got %b want 0001", req_pop);
        else passed++;
        tick();
        total++;
        if (pndng_i_in !== 1'b1 || grant_id !== 2'd0 ||
            data_out_i_in !== 32'hA0)
            $display("FAIL reset_first_grant v=%b id=%0d d=%h want 1/0/a0",
                     pndng_i_in, grant_id, data_out_i_in);
        else passed++;
    endtask

    task automatic test_fair_rr;
        int exp_id;
        enable    = 1'b1;
        req_pndng = 4'b1111;
        set_data_a0();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            exp_id = c % N;
            #1;
            total++;
            if (req_pop !== (4'b0001 << exp_id))
                $display("FAIL rr_pop c=%0d got %b want %b",
                         c, req_pop, 4'b0001 << exp_id);
            else passed++;
            tick();
            popin = 1'b1;
            total++;
            if (pndng_i_in !== 1'b1 || grant_id !== IW'(exp_id) ||
                data_out_i_in !== 32'hA0 + exp_id)
                $display("FAIL rr_grant c=%0d v=%b id=%0d d=%h want id %0d",
                         c, pndng_i_in, grant_id, data_out_i_in, exp_id);
            else passed++;
        end
        popin = 1'b0;
        total++;
        if (proto_err !== 1'b0)
            $display("FAIL rr_proto got %b want 0", proto_err);
        else passed++;
    endtask

    task automatic test_backpressure;
        int extra_pops;
        enable    = 1'b1;
        req_pndng = 4'b0100;
        req_data  = '0;
        req_data[2*PW +: PW] = 32'h1234_5678;
        do_reset();
        #1;
        total++;
        if (req_pop !== 4'b0100)
            $display("FAIL bp_pop got %b want 0100", req_pop);
        else passed++;
        tick();
        req_pndng = 4'b0000;
        req_data[2*PW +: PW] = 32'hDEAD_BEEF;
        extra_pops = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_pop !== 4'b0) extra_pops++;
            total++;
            if (pndng_i_in !== 1'b1 || data_out_i_in !== 32'h1234_5678 ||
                grant_id !== 2'd2)
                $display("FAIL bp_hold c=%0d v=%b d=%h id=%0d",
                         c, pndng_i_in, data_out_i_in, grant_id);
            else passed++;
            tick();
        end
        total++;
        if (extra_pops !== 0)
            $display("FAIL bp_extra_pops got %0d want 0", extra_pops);
        else passed++;
        popin = 1'b1;
        #1;
        total++;
        if (req_pop !== 4'b0)
            $display("FAIL bp_drain_pop got %b want 0000", req_pop);
        else passed++;
        tick();
        popin = 1'b0;
        total++;
        if (pndng_i_in !== 1'b0)
            $display("FAIL bp_idle got %b want 0", pndng_i_in);
        else passed++;
    endtask

    task automatic test_enable_drop;
        enable    = 1'b1;
        req_pndng = 4'b1111;
        set_data_a0();
        do_reset();
        tick();
        popin = 1'b1;
        tick();
        total++;
        if (grant_id !== 2'd1)
            $display("FAIL en_setup got %0d want 1", grant_id);
        else passed++;
        enable = 1'b0;
        popin  = 1'b0;
        #1;
        total++;
        if (req_pop !== 4'b0)
            $display("FAIL en_hold_pop got %b want 0000", req_pop);
        else passed++;
        tick();
        popin = 1'b1;
        #1;
        total++;
        if (req_pop !== 4'b0)
            $display("FAIL en_drain_pop got %b want 0000", req_pop);
        else passed++;
        tick();
        popin = 1'b0;
        total++;
        if (pndng_i_in !== 1'b0)
            $display("FAIL en_idle got %b want 0", pndng_i_in);
        else passed++;
        tick();
        enable = 1'b1;
        #1;
        total++;
        if (req_pop !== 4'b0100)
            $display("FAIL en_resume_pop got %b want 0100", req_pop);
        else passed++;
        tick();
        total++;
        if (grant_id !== 2'd2 || data_out_i_in !== 32'hA2 ||
            proto_err !== 1'b0)
            $display("FAIL en_resume id=%0d d=%h err=%b want 2/a2/0",
                     grant_id, data_out_i_in, proto_err);
        else passed++;
    endtask

    task automatic test_protocol_abort;
        enable    = 1'b1;
        req_pndng = 4'b0000;
        req_data  = '0;
        req_data[1*PW +: PW] = 32'h11;
        req_data[3*PW +: PW] = 32'h33;
        do_reset();
        popin = 1'b1;
        tick();
        popin = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (proto_err !== 1'b1)
                $display("FAIL proto_sticky c=%0d got %b want 1", c, proto_err);
            else passed++;
            tick();
        end
        req_pndng = 4'b0010;
        #1;
        total++;
        if (req_pop !== 4'b0010)
            $display("FAIL proto_pop1 got %b want 0010", req_pop);
        else passed++;
        tick();
        req_pndng = 4'b1010;
        total++;
        if (pndng_i_in !== 1'b1 || grant_id !== 2'd1)
            $display("FAIL proto_hold v=%b id=%0d want 1/1", pndng_i_in, grant_id);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (req_pop !== 4'b0)
            $display("FAIL abort_pop got %b want 0000", req_pop);
        else passed++;
        tick();
        total++;
        if (pndng_i_in !== 1'b0 || proto_err !== 1'b0 || grant_id !== 2'd0)
            $display("FAIL abort_state v=%b err=%b id=%0d want 0/0/0",
                     pndng_i_in, proto_err, grant_id);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (req_pop !== 4'b0010)
            $display("FAIL abort_pop_after got %b want 0010", req_pop);
        else passed++;
        tick();
        total++;
        if (grant_id !== 2'd1 || data_out_i_in !== 32'h11)
            $display("FAIL abort_grant id=%0d d=%h want 1/11",
                     grant_id, data_out_i_in);
        else passed++;
        req_pndng = 4'b0000;
        popin = 1'b1;
        tick();
        popin = 1'b0;
    endtask

`ifdef MESH_TERM_ARB_STATS_EN
    task automatic test_stats;
        enable    = 1'b1;
        req_pndng = 4'b1111;
        set_data_a0();
        do_reset();
        tick();
        popin = 1'b1;
        tick();
        tick();
        tick();
        req_pndng = 4'b1000;
        for (int c = 0; c < 70000; c++)
            tick();
        req_pndng = 4'b0000;
        tick();
        popin = 1'b0;
        total++;
        if (grant_cnt[3*16 +: 16] !== 16'hFFFF)
            $display("FAIL stats_sat got %h want ffff", grant_cnt[3*16 +: 16]);
        else passed++;
        total++;
        if (grant_cnt[0 +: 48] !== {16'd1, 16'd1, 16'd1})
            $display("FAIL stats_low got %h want 000100010001",
                     grant_cnt[0 +: 48]);
        else passed++;
    endtask
`endif

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        popin     = 1'b0;
        req_pndng = '0;
        req_data  = '0;
        test_reset();
        test_fair_rr();
        test_backpressure();
        test_enable_drop();
        test_protocol_abort();
`ifdef MESH_TERM_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mesh_term_inject_arb.md
Name: mesh_term_inject_arb

Overview:
- Round-robin injection arbiter that shares one mesh terminal input port among N_REQ local packet sources. Sources are FIFO-style producers with pending, head-data and pop signals.
- Holds one packet in an output register. Presents it to the router through the router's terminal-input handshake (pndng_i_in, data_out_i_in, popin).
- Sits between the per-terminal source FIFOs and one terminal of mesh_gnrtr. Packets pass unmodified.

Parameters:
- N_REQ, 4, number of sources (2..8)
- PAKG_SIZE, 32, packet width in bits
- ID_W, $clog2(N_REQ), grant id width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = new grants allowed
- req_pndng  in  N_REQ  source i has a packet at its head
- req_data  in  N_REQ*PAKG_SIZE  head packet of source i, slice [i*PAKG_SIZE +: PAKG_SIZE]
- req_pop  out  N_REQ  one-cycle pop to source i; at most one bit set
- pndng_i_in  out  1  holding register valid (to router)
- data_out_i_in  out  PAKG_SIZE  holding register contents (to router)
- popin  in  1  router consumed the presented packet
- grant_id  out  ID_W  source of the packet currently held
- proto_err  out  1  sticky; set by popin while pndng_i_in=0

Behaviour:
- Reset: single clk and reset, synchronous active-high. All outputs are 0, state is IDLE, and rr_ptr = N_REQ-1 so source 0 wins first.
- Reset mid-HOLD drops the held packet. No req_pop is issued in the reset cycle.
- States:
  - IDLE: holding register empty.
  - HOLD: pndng_i_in=1, data_out_i_in stable, grant_id stable.
- Arbitration is combinational within the granting cycle. Search order is rr_ptr+1, rr_ptr+2, ... mod N_REQ. The first i with req_pndng[i]=1 is the winner w.
- A grant happens in a cycle when enable=1, some req_pndng bit is set, and either:
  - state=IDLE, or
  - state=HOLD and popin=1.
- In a grant cycle:
  - req_pop[w]=1 combinationally.
  - req_data[w] is captured into the holding register.
  - grant_id<=w, rr_ptr<=w, next state HOLD.
- Latency: req_pndng seen in IDLE at edge t gives pndng_i_in=1 after edge t.
- Throughput: back-to-back refill on popin yields 1 packet/cycle with no bubble.
- HOLD and popin=1 with no grant possible (enable=0 or no pending source): next state IDLE, pndng_i_in<=0. data_out_i_in keeps its last value but is don't-care.
- HOLD and popin=0: hold everything. No req_pop. Source changes have no effect on the held packet.
- req_pop is never asserted for a source whose req_pndng=0, and is never asserted in a cycle that does not fill the holding register.
- enable=0: the current HOLD completes normally; no new grant. rr_ptr is frozen.
- popin while state=IDLE: ignored, proto_err<=1. proto_err clears only on reset.
- Single pending source: it is granted on every opportunity (RR degenerates gracefully).
- Fairness: with all sources continuously pending, grants follow 0,1,2,...,N_REQ-1,0,...
  - No source waits more than N_REQ-1 grants.

Optional Feature:
- Macro: MESH_TERM_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt [N_REQ*16].
  - Slice i counts grants to source i, +1 per grant cycle.
  - Saturates at 16'hFFFF (no wrap). Cleared by reset.
- Undefined: port and counters absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset 3 cycles with req_pndng=4'b1111 -> req_pop=0, pndng_i_in=0, grant_id=0, proto_err=0. First grant after release goes to source 0.
- Fair RR: N_REQ=4, all sources pending with distinct data (0xA0+i), popin tied 1 -> grant_id sequence 0,1,2,3,0,1.
  - One packet per cycle; data_out_i_in matches 0xA0+grant_id.
  - Exactly one req_pop bit per cycle.
- Backpressure: source 2 only, data 0x1234_5678, popin held 0 for 20 cycles -> pndng_i_in=1 and data stable for all 20 cycles, single req_pop[2] pulse. popin=1 for one cycle -> return to IDLE when no more pending.
- enable drop: in HOLD with all pending, enable=0 then popin=1 -> state IDLE, no req_pop.
  - enable=1 -> next grant is (previous winner+1) mod 4.
- Protocol and reset-abort: popin=1 in IDLE -> proto_err=1, sticky for 10 cycles. Then grant source 1 and assert reset during HOLD -> pndng_i_in=0 next cycle, proto_err=0, first post-reset grant to lowest pending index.
- Stats (MESH_TERM_ARB_STATS_EN): 70000 grants to source 3 -> grant_cnt slice 3 = 16'hFFFF, other slices equal their grant counts.
